// File: rtl/vault_siren_ctrl.sv
// Siren sequencer shared by the vault alarm (entry delay, timed siren, silenced memory, ack)
// and the end-of-shift beep; a vault violation always pre-empts or blocks the beep.
module vault_siren_ctrl #(
  parameter int ENTRY_DELAY   = 3,
  parameter int ALARM_TIMEOUT = 8,
  parameter int SHIFT_CYCLES  = 4,
  parameter int CNT_W         = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             door,
  input  logic             business_hours,
  input  logic             override,
  input  logic             shift_req,
  input  logic             ack,
  output logic             siren,
  output logic             pre_alarm,
  output logic             alarm_mem,
  output logic             shift_pending,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] count
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ENTRY  = 3'd1;
  localparam logic [2:0] ST_ALARM  = 3'd2;
  localparam logic [2:0] ST_SILENT = 3'd3;
  localparam logic [2:0] ST_SHIFT  = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ENTRY_LD  = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] ALARM_LD  = CNT_W'(ALARM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SHIFT_LD  = CNT_W'(SHIFT_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             shift_prev;
  logic             viol, rise, to_shift;

  assign viol = door & (override | ~business_hours);
  assign rise = shift_req & ~shift_prev;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      shift_prev <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      shift_prev <= shift_req;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    to_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (viol) begin
          state_d = ST_ENTRY;
          cnt_d   = ENTRY_LD;
        end else if (rise | pending_q) begin
          state_d  = ST_SHIFT;
          cnt_d    = SHIFT_LD;
          to_shift = 1'b1;
        end
      end
      ST_ENTRY: begin
        if (!viol) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ALARM;
          cnt_d   = ALARM_LD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ALARM: begin
        // Operator ack outranks the auto-silence timeout.
        if (ack && !viol) begin
          state_d = ST_IDLE;
        end else if (ack || cnt_q == '0) begin
          state_d = ST_SILENT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_SILENT: begin
        if (ack && !viol) state_d = ST_IDLE;
      end
      ST_SHIFT: begin
        // Violation drops the rest of the beep; it is not re-queued.
        if (viol) begin
          state_d = ST_ENTRY;
          cnt_d   = ENTRY_LD;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pending_d = to_shift ? 1'b0 : (pending_q | rise);
  end

  always_comb begin
    siren         = (state_q == ST_ALARM) | ((state_q == ST_SHIFT) & cnt_q[0]);
    pre_alarm     = (state_q == ST_ENTRY);
    alarm_mem     = (state_q == ST_ALARM) | (state_q == ST_SILENT);
    shift_pending = pending_q;
    state         = state_q;
    count         = cnt_q;
  end

endmodule

// File: doc/vault_siren_ctrl.md
# vault_siren_ctrl

Sequencing controller for the board's single siren output, shared between the bank-vault alarm and the end-of-shift signal. It adds entry delay, timed siren, silenced-alarm memory and operator acknowledge around the vault violation condition, and arbitrates the siren so a vault alarm always pre-empts or blocks the shift beep. It sits in `top`, fed from `SWI`, driving `LED`/`SEG`, clocked by `clk_2` (about 0.5 Hz, so one cycle is about 2 s).

## Interface
- `ENTRY_DELAY`, default 3: cycles from violation to siren; must be ≥1.
- `ALARM_TIMEOUT`, default 8: cycles the siren sounds before auto-silence; must be ≥1.
- `SHIFT_CYCLES`, default 4: length of the shift beep pattern; must be ≥1, even by convention.
- `CNT_W`, default 4: counter width; must hold max(parameter)−1.

- `clk_2`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `door`  in  1  vault door open.
- `business_hours`  in  1  time-lock clock reports opening hours.
- `override`  in  1  manager alarm switch.
- `shift_req`  in  1  end-of-shift condition (level); a rising edge requests one beep sequence.
- `ack`  in  1  operator acknowledge (level, sampled each cycle).
- `siren`  out  1  shared siren drive.
- `pre_alarm`  out  1  high in ENTRY.
- `alarm_mem`  out  1  high in ALARM or SILENT.
- `shift_pending`  out  1  one-deep queued shift request.
- `state`  out  3  current state code.
- `count`  out  CNT_W  current down-counter value.

## Operation
- Violation: `v = door & (override | ~business_hours)`, evaluated combinationally from the current inputs.
- Shift edge: `rise = shift_req & ~shift_prev`. `shift_prev` is a register updated every cycle.
- State codes: IDLE=0, ENTRY=1, ALARM=2, SILENT=3, SHIFT=4. Codes 5–7 are illegal and go to IDLE on the next edge.
- IDLE (siren=0):
  - If `v`: go to ENTRY, `cnt←ENTRY_DELAY−1`.
  - Else if `rise|pending`: go to SHIFT, `cnt←SHIFT_CYCLES−1`, clear pending.
  - Else stay.
- ENTRY (siren=0):
  - If `~v`: go to IDLE (cancelled).
  - Else if `cnt==0`: go to ALARM, `cnt←ALARM_TIMEOUT−1`.
  - Else `cnt−1`.
  - `ack` is ignored.
- ALARM (siren=1):
  - If `ack & ~v`: go to IDLE.
  - Else if `ack`: go to SILENT.
  - Else if `cnt==0`: go to SILENT.
  - Else `cnt−1`.
  - `ack` takes priority over timeout.
- SILENT (siren=0): `ack & ~v` goes to IDLE; otherwise stay.
- SHIFT (siren=`cnt[0]`):
  - If `v`: go to ENTRY, `cnt←ENTRY_DELAY−1`. The alarm pre-empts; the remaining beep sequence is dropped and not re-queued.
  - Else if `cnt==0`: go to IDLE.
  - Else `cnt−1`.
- Pending flag:
  - Set on any cycle where `rise` occurs and the same-cycle transition is not IDLE→SHIFT.
  - Cleared on IDLE→SHIFT.
  - Further edges while set merge into it; there is no counting.
  - Pending survives ALARM/SILENT and is served on return to IDLE.
- `cnt` holds its value in IDLE and SILENT.

## Timing
- All outputs are Moore outputs: decoded from registered state/cnt/pending only. There is no combinational input-to-output path.
- Reset values: state=IDLE, cnt=0, pending=0, shift_prev=0, siren=0, pre_alarm=0, alarm_mem=0, shift_pending=0.
- Reset wins over every other event. Reset asserted mid-ALARM gives siren=0 after that edge.
- `shift_req` held high through reset produces one `rise` on the first cycle after reset.
- `v` sampled at edge t (IDLE): ENTRY from t+1; siren rises after edge t+ENTRY_DELAY; siren stays high ALARM_TIMEOUT cycles unless acked.
- `rise` at edge t in IDLE with `~v`: SHIFT from t+1. Siren pattern for cnt=S−1…0 is `cnt[0]`; for S=4 this is 1,0,1,0. Back to IDLE after S cycles.
- `v` and `rise` in the same IDLE cycle: go to ENTRY and set pending.

## Test plan
- Reset, then door=1, override=0, business_hours=0 held → pre_alarm for 3 cycles, then siren=1 for exactly 8 cycles, then SILENT (alarm_mem=1, siren=0). door=0 plus ack → IDLE on the next edge.
- Violation for 2 cycles, then door=0 → ENTRY→IDLE, siren never asserts, count sequence 2,1.
- In ALARM, ack=1 with door still 1 → SILENT, siren=0. Then ack with door=0 → IDLE. Check ack beats timeout when both occur at cnt=0.
- shift_req rising in IDLE → siren 1,0,1,0 over 4 cycles, then IDLE. A second rising edge mid-SHIFT → shift_pending=1, and a second 4-cycle pattern starts immediately after.
- Violation at cnt=2 of SHIFT → ENTRY next cycle with count=2; the shift sequence is not repeated unless pending was set.
- Reset asserted mid-ALARM with shift_req high → all outputs 0 after the edge; one SHIFT sequence starts the cycle after reset deasserts, provided `v`=0.
